// File: rtl/seq_pkg.sv
// Shared types for the bit-serial sequence-detector front end.
//   ser_state_t        : serializer shifter state
//   SER_NBITS_DEFAULT  : default serialized word width
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int unsigned SER_NBITS_DEFAULT = 8;

endpackage

// File: rtl/seq_bit_serializer_buf.sv
// One-entry input buffer for seq_bit_serializer.
//   clk, reset : clock, synchronous active-high reset
//   in_val     : upstream word valid
//   in_rdy     : buffer empty, can accept a word (registered state only)
//   in_msg     : upstream word
//   deq        : consumer takes the buffered word this cycle
//   out_full   : buffer holds a word
//   out_msg    : buffered word
module seq_bit_serializer_buf #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  input  logic             deq,
  output logic             out_full,
  output logic [NBITS-1:0] out_msg
);

  logic             full_q, full_d;
  logic [NBITS-1:0] msg_q,  msg_d;

  // Buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      msg_q  <= '0;
    end else begin
      full_q <= full_d;
      msg_q  <= msg_d;
    end
  end

  // Enqueue only when empty; dequeue only when full, so the two never coincide
  always_comb begin
    full_d = full_q;
    msg_d  = msg_q;
    if (deq) begin
      full_d = 1'b0;
    end
    if (in_val && !full_q) begin
      full_d = 1'b1;
      msg_d  = in_msg;
    end
  end

  assign in_rdy   = !full_q;
  assign out_full = full_q;
  assign out_msg  = msg_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: accepts NBITS-bit words over val/rdy and emits
// them MSB-first, one bit per cycle, with back-to-back words gap-free.
//   clk, reset : clock, synchronous active-high reset
//   in_val     : upstream word valid
//   in_rdy     : a word can be accepted this cycle
//   in_msg     : word to serialize, bit NBITS-1 first
//   out_bit    : serial bit (IDLE_BIT when no data)
//   out_val    : out_bit carries a data bit
//   busy       : shifting or a word is buffered
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned NBITS    = SER_NBITS_DEFAULT,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_bit,
  output logic             out_val,
  output logic             busy
);

  localparam int unsigned         CNT_W    = $clog2(NBITS);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(NBITS - 1);

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;

  logic             buf_full;
  logic [NBITS-1:0] buf_msg;
  logic             last_bit;
  logic             load;

  seq_bit_serializer_buf #(
    .NBITS (NBITS)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .deq      (load),
    .out_full (buf_full),
    .out_msg  (buf_msg)
  );

  // A buffered word loads when the shifter is idle or on its last bit
  assign last_bit = (state_q == SER_SHIFT) && (cnt_q == CNT_LAST);
  assign load     = buf_full && ((state_q == SER_IDLE) || last_bit);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next state: load wins over the return to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE:  if (load) state_d = SER_SHIFT;
      SER_SHIFT: if (!load && last_bit) state_d = SER_IDLE;
      default:   state_d = SER_IDLE;
    endcase
  end

  // Shift register and bit counter
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = buf_msg;
      cnt_d   = '0;
    end else if (state_q == SER_SHIFT) begin
      shreg_d = shreg_q << 1;
      cnt_d   = CNT_W'(cnt_q + 1'b1);
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    out_val = (state_q == SER_SHIFT);
    out_bit = out_val ? shreg_q[NBITS-1] : IDLE_BIT;
    busy    = out_val || buf_full;
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
module tb_seq_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, IDLE_BIT=0 instance
  logic       reset8, in_val8, in_rdy8, out_bit8, out_val8, busy8;
  logic [7:0] in_msg8;
  // 2-bit, IDLE_BIT=1 instance
  logic       reset2, in_val2, in_rdy2, out_bit2, out_val2, busy2;
  logic [1:0] in_msg2;

  seq_bit_serializer #(.NBITS(8), .IDLE_BIT(1'b0)) dut8 (
    .clk(clk), .reset(reset8), .in_val(in_val8), .in_rdy(in_rdy8), .in_msg(in_msg8),
    .out_bit(out_bit8), .out_val(out_val8), .busy(busy8));

  seq_bit_serializer #(.NBITS(2), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .reset(reset2), .in_val(in_val2), .in_rdy(in_rdy2), .in_msg(in_msg2),
    .out_bit(out_bit2), .out_val(out_val2), .busy(busy2));

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: buffered word plus the word in flight and how many of its
  // bits remain; index 0 = 8-bit instance, 1 = 2-bit instance.
  int          nb   [2] = '{8, 2};
  logic        idle [2] = '{1'b0, 1'b1};
  logic        m_full[2];
  logic [31:0] m_buf [2];
  logic [31:0] m_word[2];
  int          m_left[2];

  function automatic logic exp_val(input int d);
    return m_left[d] > 0;
  endfunction

  function automatic logic exp_bit(input int d);
    return (m_left[d] > 0) ? m_word[d][m_left[d]-1] : idle[d];
  endfunction

  task automatic model_step(input int d, input logic v, input logic [31:0] msg, input logic rst);
    logic was_full;
    if (rst) begin
      m_full[d] = 1'b0;
      m_left[d] = 0;
      return;
    end
    was_full = m_full[d];
    if (m_left[d] > 0) m_left[d]--;
    if (was_full && m_left[d] == 0) begin
      m_word[d] = m_buf[d];
      m_left[d] = nb[d];
      m_full[d] = 1'b0;
    end
    if (v && !was_full) begin
      m_full[d] = 1'b1;
      m_buf[d]  = msg;
    end
  endtask

  bit   checking = 0;
  logic hist8[$];
  logic hist2[$];
  int   run8, maxrun8, run2, maxrun2;

  task automatic check_outs();
    chk("d8_rdy", 32'(in_rdy8),  32'(!m_full[0]));
    chk("d8_val", 32'(out_val8), 32'(exp_val(0)));
    chk("d8_bit", 32'(out_bit8), 32'(exp_bit(0)));
    chk("d8_busy", 32'(busy8),   32'(exp_val(0) || m_full[0]));
    chk("d2_rdy", 32'(in_rdy2),  32'(!m_full[1]));
    chk("d2_val", 32'(out_val2), 32'(exp_val(1)));
    chk("d2_bit", 32'(out_bit2), 32'(exp_bit(1)));
    chk("d2_busy", 32'(busy2),   32'(exp_val(1) || m_full[1]));
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model
  task automatic tick(input logic v8, input logic [7:0] g8, input logic r8,
                      input logic v2, input logic [1:0] g2, input logic r2);
    @(negedge clk);
    if (checking) check_outs();
    if (out_val8) begin hist8.push_back(out_bit8); run8++; end else run8 = 0;
    if (out_val2) begin hist2.push_back(out_bit2); run2++; end else run2 = 0;
    if (run8 > maxrun8) maxrun8 = run8;
    if (run2 > maxrun2) maxrun2 = run2;
    in_val8 = v8; in_msg8 = g8; reset8 = r8;
    in_val2 = v2; in_msg2 = g2; reset2 = r2;
    @(posedge clk);
    model_step(0, v8, 32'(g8), r8);
    model_step(1, v2, 32'(g2), r2);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic clear_hist();
    hist8.delete(); hist2.delete();
    run8 = 0; maxrun8 = 0; run2 = 0; maxrun2 = 0;
  endtask

  function automatic logic [31:0] hist_val(input int d);
    logic [31:0] v = '0;
    if (d == 0) foreach (hist8[i]) v = {v[30:0], hist8[i]};
    else        foreach (hist2[i]) v = {v[30:0], hist2[i]};
    return v;
  endfunction

  // Offer words to instance d as fast as the buffer frees; junk in_msg while full
  logic [31:0] wq[$];
  task automatic stream(input int d);
    int budget = 1000;
    while (wq.size() > 0 && budget > 0) begin
      logic        acc = !m_full[d];
      logic [31:0] msg = acc ? wq[0] : $urandom;
      if (d == 0) tick(1'b1, 8'(msg), 1'b0, 1'b0, 2'b00, 1'b0);
      else        tick(1'b0, 8'h00, 1'b0, 1'b1, 2'(msg), 1'b0);
      if (acc) void'(wq.pop_front());
      budget--;
    end
    if (wq.size() > 0) begin
      chk("stream_timeout", 32'(wq.size()), 32'd0);
      wq.delete();
    end
  endtask

  initial begin
    int budget;
    m_full = '{1'b0, 1'b0}; m_left = '{0, 0};
    m_buf = '{32'd0, 32'd0}; m_word = '{32'd0, 32'd0};
    clear_hist();

    // Reset both instances, then idle
    tick(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
    checking = 1;
    idle_ticks(5);

    // Single word 8'hA0
    clear_hist();
    tick(1'b1, 8'hA0, 1'b0, 1'b0, 2'b00, 1'b0);
    idle_ticks(12);
    chk("t2_bits", hist_val(0), 32'hA0);
    chk("t2_len", 32'(hist8.size()), 32'd8);
    chk("t2_run", 32'(maxrun8), 32'd8);

    // Back-to-back A5,3C,FF with junk in_msg while the buffer is full
    clear_hist();
    wq = '{32'hA5, 32'h3C, 32'hFF};
    stream(0);
    idle_ticks(20);
    chk("t3_bits", hist_val(0), 32'hA53CFF);
    chk("t3_run", 32'(maxrun8), 32'd24);

    // Reset at cnt=3 of F0 while 0F is buffered
    wq = '{32'hF0, 32'h0F};
    stream(0);
    budget = 50;
    while (!(m_left[0] == 5 && m_full[0]) && budget > 0) begin
      idle_ticks(1);
      budget--;
    end
    chk("t5_setup", 32'(budget > 0), 32'd1);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
    clear_hist();
    idle_ticks(20);
    chk("t5_dropped", 32'(hist8.size()), 32'd0);

    // NBITS=2, IDLE_BIT=1 stream
    clear_hist();
    wq = '{32'h2, 32'h1, 32'h3};
    stream(1);
    idle_ticks(8);
    chk("t6_bits", hist_val(1), 32'b100111);
    chk("t6_run", 32'(maxrun2), 32'd6);

    // Random traffic and occasional resets on both instances
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 2) != 0), 2'($urandom), 1'($urandom_range(0, 99) == 0));
    end
    idle_ticks(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
